mem_march_bist: RTL
===================

MEM_MARCH_BIST -- requirements
Module: mem_march_bist

Interface
REQ-001 Parameters SHALL be: none; the block is fixed at 256 words x 8 bits, 8-bit address.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  begin test; sampled only in IDLE, DONE or FAIL.
REQ-005 pat  input  8  background pattern; latched on the start-sampling edge.
REQ-006 busy  output  1  high while the test runs.
REQ-007 done  output  1  high in DONE or FAIL; held until the next accepted start.
REQ-008 fail  output  1  high in FAIL only.
REQ-009 fail_addr  output  8  address of the first mismatch.
REQ-010 fail_data  output  8  data read at the first mismatch.
REQ-011 mem_rd  output  1  memory read strobe.
REQ-012 mem_wr  output  1  memory write strobe.
REQ-013 mem_addr  output  8  memory address.
REQ-014 mem_din  output  8  memory write data.
REQ-015 mem_dout  input  8  memory read data; combinational, valid in the same cycle as mem_rd.

Function
REQ-016 States SHALL be IDLE, W0, R1, W1, R2, W2, R3, DONE and FAIL, with an 8-bit address counter and a latched pattern register P.
REQ-017 March sequence SHALL be:
- W0: ascending, write P.
- R1/W1: ascending, read expect P, then write ~P at the same address.
- R2/W2: descending 0xFF..0x00, read expect ~P, then write P.
- R3: ascending, read expect P.
REQ-018 Each state SHALL occupy exactly one cycle per address, giving 256+512+512+256 = 1536 test cycles.
REQ-019 mem_rd and mem_wr SHALL be decoded from state and counter only, and SHALL never be high together.
REQ-020 Strobes SHALL be mem_rd=1 in R1, R2 and R3, and mem_wr=1 in W0, W1 and W2.
REQ-021 mem_din SHALL be 0 whenever mem_wr=0; mem_addr SHALL be 0 in IDLE, DONE and FAIL.
REQ-022 Comparison of mem_dout against expected data SHALL occur at the rising edge ending each read cycle.
REQ-023 On the first mismatch, the FSM SHALL:
- latch fail_addr and fail_data;
- enter FAIL;
- issue no further memory access.
REQ-024 After the last R3 compare (address 0xFF) with no mismatch, the FSM SHALL enter DONE.
REQ-025 Transitions:
- W0 to R1 after address 0xFF.
- W1 to R1 while address < 0xFF, else to R2 with the counter at 0xFF.
- W2 to R2 while address > 0x00, else to R3 with the counter at 0x00.
REQ-026 Counter wrap SHALL never occur; the pass boundaries in REQ-025 take priority.
REQ-027 start=1 while busy SHALL be ignored, and pat changes while busy SHALL be ignored.
REQ-028 start in DONE or FAIL SHALL restart at W0 with address 0 and SHALL clear fail, fail_addr and fail_data on the same edge.
REQ-029 busy SHALL be high from the edge after start is sampled until the edge entering DONE or FAIL.
REQ-030 done SHALL rise exactly 1536 cycles after the start-sampling edge in a fault-free run.

Reset
REQ-031 With rst=0 at a rising edge, the block SHALL:
- enter IDLE;
- clear the counter and P;
- drive busy, done, fail, fail_addr, fail_data, mem_rd, mem_wr, mem_addr and mem_din to 0.
REQ-032 Reset SHALL take priority over start and abort a running test with no further memory write.

Verification
REQ-033 Fault-free 256x8 memory model, pat=0xA5, single start pulse -> busy for 1536 cycles, mem_rd/mem_wr never both high, then done=1, fail=0.
REQ-034 Model with bit0 of address 0x10 stuck at 0, pat=0xA5 -> fail=1, done=1, fail_addr=0x10, fail_data=0xA4, busy low after the 289th edge following start.
REQ-035 Model ignoring writes to 0xFF after W0, pat=0xA5 -> first R2 read fails: fail_addr=0xFF, fail_data=0xA5 (expected 0x5A).
REQ-036 rst=0 on cycle 700 of a run -> next edge gives all outputs 0 and IDLE; a later start runs the full 1536 cycles.
REQ-037 start pulsed while busy, and pat changed mid-run -> no restart and the comparison still uses the originally latched pattern.
REQ-038 start in FAIL with a now-good model -> fail, fail_addr and fail_data clear, then done=1, fail=0 after 1536 cycles.

Source files
------------

// File: rtl/mem_march_bist.sv
// March-style BIST for a 256x8 synchronous-write / combinational-read memory.
// Runs W0, R1/W1 ascending, R2/W2 descending, R3 ascending; stops at the first mismatch.
module mem_march_bist (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pat,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [7:0] fail_addr,
    output logic [7:0] fail_data,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_din,
    input  logic [7:0] mem_dout
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_W0   = 4'd1;
    localparam logic [3:0] S_R1   = 4'd2;
    localparam logic [3:0] S_W1   = 4'd3;
    localparam logic [3:0] S_R2   = 4'd4;
    localparam logic [3:0] S_W2   = 4'd5;
    localparam logic [3:0] S_R3   = 4'd6;
    localparam logic [3:0] S_DONE = 4'd7;
    localparam logic [3:0] S_FAIL = 4'd8;

    localparam logic [AW-1:0] ADDR_MAX = '1;

    logic [3:0]    state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic [DW-1:0] p, p_nx;
    logic [AW-1:0] fa_nx;
    logic [DW-1:0] fd_nx;
    logic [DW-1:0] exp_c;
    logic          miscompare_c;
    logic          active_c;

    // Read passes R1 and R3 expect P; the descending pass R2 expects ~P.
    assign exp_c        = (state == S_R2) ? ~p : p;
    assign miscompare_c = (mem_dout != exp_c);

    // State register and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            p         <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            p         <= p_nx;
            fail_addr <= fa_nx;
            fail_data <= fd_nx;
        end
    end

    // Next-state, counter and fail-capture logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        p_nx     = p;
        fa_nx    = fail_addr;
        fd_nx    = fail_data;
        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_nx = S_W0;
                    cnt_nx   = '0;
                    p_nx     = pat;
                    fa_nx    = '0;
                    fd_nx    = '0;
                end
            end
            S_W0: begin
                if (cnt == ADDR_MAX) begin
                    state_nx = S_R1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + AW'(1);
                end
            end
            S_R1, S_R2: begin
                if (miscompare_c) begin
                    state_nx = S_FAIL;
                    fa_nx    = cnt;
                    fd_nx    = mem_dout;
                end else begin
                    state_nx = (state == S_R1) ? S_W1 : S_W2;
                end
            end
            S_W1: begin
                if (cnt == ADDR_MAX) begin
                    state_nx = S_R2;
                end else begin
                    state_nx = S_R1;
                    cnt_nx   = cnt + AW'(1);
                end
            end
            S_W2: begin
                if (cnt == '0) begin
                    state_nx = S_R3;
                end else begin
                    state_nx = S_R2;
                    cnt_nx   = cnt - AW'(1);
                end
            end
            S_R3: begin
                if (miscompare_c) begin
                    state_nx = S_FAIL;
                    fa_nx    = cnt;
                    fd_nx    = mem_dout;
                end else if (cnt == ADDR_MAX) begin
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt + AW'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Status and memory strobes decode straight from the state and counter registers.
    assign active_c = (state == S_W0) || (state == S_R1) || (state == S_W1) ||
                      (state == S_R2) || (state == S_W2) || (state == S_R3);

    assign busy     = active_c;
    assign done     = (state == S_DONE) || (state == S_FAIL);
    assign fail     = (state == S_FAIL);
    assign mem_rd   = (state == S_R1) || (state == S_R2) || (state == S_R3);
    assign mem_wr   = (state == S_W0) || (state == S_W1) || (state == S_W2);
    assign mem_addr = active_c ? cnt : '0;
    assign mem_din  = (state == S_W1) ? ~p : (mem_wr ? p : '0);

endmodule
